// File: rtl/key_event_unit.sv
// key_event_unit: debounced key event latch with W1C press/release bits and a maskable irq
// Ports: clk; reset (async, active-high); user_key[7:0] raw active-low pins;
//   we/addr[1:0]/din[31:0] register writes; dout[31:0] combinational read of reg[addr]; irq level.
// Registers: 0 STATE, 1 PRESS (W1C), 2 MASK, 3 RELEASE (W1C, only with KEY_RELEASE_EDGE_EN).
// Optional: define KEY_RELEASE_EDGE_EN to capture 1->0 STATE transitions in RELEASE.
module key_event_unit #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  user_key,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [7:0] sync1_q, sync2_q, s, state_q, state_d, press_q, press_d, mask_q, mask_d, rel;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic unused_din;
  assign unused_din = ^din[31:8];
  assign s = ~sync2_q;
  // a counter only runs while the synchronised level disagrees with STATE; any agreement restarts it
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < 8; i++) begin
      state_d[i] = (s[i] != state_q[i] && cnt_q[i] == LAST) ? s[i] : state_q[i];
      cnt_d[i] = (s[i] == state_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + 1'b1;
    end
  end
  // OR-ing the new edge after the W1C mask makes a same-cycle set win over the clear
  assign press_d = (press_q & ~((we && addr == 2'd1) ? din[7:0] : 8'h00)) | (state_d & ~state_q);
  assign mask_d = (we && addr == 2'd2) ? din[7:0] : mask_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 8'hFF;
      sync2_q <= 8'hFF;
      state_q <= '0;
      press_q <= '0;
      mask_q <= '0;
      cnt_q <= '{default: '0};
    end else begin
      sync1_q <= user_key;
      sync2_q <= sync1_q;
      state_q <= state_d;
      press_q <= press_d;
      mask_q <= mask_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef KEY_RELEASE_EDGE_EN
  logic [7:0] release_q, release_d;
  assign release_d = (release_q & ~((we && addr == 2'd3) ? din[7:0] : 8'h00)) | (state_q & ~state_d);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) release_q <= '0;
    else release_q <= release_d;
  end
  assign rel = release_q;
`else
  assign rel = 8'h00;
`endif
  assign irq = |((press_q | rel) & mask_q);
  assign dout = {24'h0, addr == 2'd0 ? state_q : addr == 2'd1 ? press_q : addr == 2'd2 ? mask_q : rel};
endmodule

// File: tb/tb_key_event_unit.sv
// tb_key_event_unit: directed bench for key_event_unit with a behavioural reference model
module tb_key_event_unit;
  localparam int D = 4;
  logic clk = 0, reset = 1, we = 0, irq;
  logic [7:0] user_key = 8'hFF;
  logic [1:0] addr = 0;
  logic [31:0] din = 0, dout;
  int n_cmp = 0, n_fail = 0;

  key_event_unit #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .user_key(user_key), .we(we),
    .addr(addr), .din(din), .dout(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  // Model: a key's debounced level takes the synchronised level (pin delayed two
  // clocks, inverted) once that level has disagreed with it for D consecutive clocks.
  logic [7:0] hist [0:D+1];
  logic [7:0] m_state = 0, m_press = 0, m_mask = 0, m_rel = 0;
  logic [7:0] f, ns, clr;

  initial begin
    for (int k = 0; k <= D + 1; k++) hist[k] = 8'hFF;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int k = 0; k <= D + 1; k++) hist[k] = 8'hFF;
        m_state = 0; m_press = 0; m_mask = 0; m_rel = 0;
      end else begin
        for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = user_key;
        f = 8'hFF;
        for (int k = 2; k <= D + 1; k++) f = f & (~hist[k] ^ m_state);
        ns = m_state ^ f;
        clr = (we && addr == 2'd1) ? din[7:0] : 8'h00;
        m_press = (m_press & ~clr) | (f & ns);
        if (we && addr == 2'd2) m_mask = din[7:0];
`ifdef KEY_RELEASE_EDGE_EN
        clr = (we && addr == 2'd3) ? din[7:0] : 8'h00;
        m_rel = (m_rel & ~clr) | (f & ~ns);
`endif
        m_state = ns;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  logic [7:0] m_sel;
  initial forever begin
    @(negedge clk);
    m_sel = addr == 2'd0 ? m_state : addr == 2'd1 ? m_press : addr == 2'd2 ? m_mask : m_rel;
    chk("model_dout", dout, reset ? 32'h0 : {24'h0, m_sel});
    chk("model_irq", {31'h0, irq}, reset ? 32'h0 : {31'h0, |((m_press | m_rel) & m_mask)});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    addr = a;
    #1;
    chk(nm, dout, e);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; din = d; we = 1;
    tick(1);
    we = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tick(3);
    reset = 0;
    for (int a = 0; a < 4; a++) rd(2'(a), 0, "reset_read");
    chk("reset_irq", {31'h0, irq}, 0);
    tick(20);
    rd(0, 0, "idle_state");
    rd(1, 0, "idle_press");
    // key 0: STATE rises exactly D+2 clocks after the pin edge
    wr(2, 32'h01);
    user_key = 8'hFE;
    tick(5);
    rd(0, 0, "k0_state_early");
    chk("k0_irq_early", {31'h0, irq}, 0);
    tick(1);
    rd(0, 32'h01, "k0_state");
    rd(1, 32'h01, "k0_press");
    chk("k0_irq", {31'h0, irq}, 1);
    wr(1, 32'h01);
    rd(1, 0, "k0_w1c");
    chk("k0_irq_clr", {31'h0, irq}, 0);
    user_key = 8'hFF;
    tick(8);
    rd(0, 0, "k0_released");
    // key 3 bounce never reaches D stable samples
    user_key = 8'hF7; tick(3);
    user_key = 8'hFF; tick(1);
    user_key = 8'hF7; tick(3);
    user_key = 8'hFF; tick(10);
    rd(0, 0, "bounce_state");
    rd(1, 0, "bounce_press");
    // key 5: set wins over simultaneous W1C
    wr(2, 32'h20);
    user_key = 8'hDF; tick(8);
    rd(0, 32'h20, "k5_state");
    wr(1, 32'h20);
    rd(1, 0, "k5_clr");
    user_key = 8'hFF; tick(8);
    user_key = 8'hDF; tick(5);
    wr(1, 32'h20);
    rd(1, 32'h20, "k5_set_wins");
    chk("k5_irq", {31'h0, irq}, 1);
    wr(2, 0);
    rd(1, 32'h20, "k5_press_masked");
    chk("k5_irq_masked", {31'h0, irq}, 0);
    user_key = 8'hFF; tick(8);
    wr(1, 32'hFF);
    // reset mid-count on key 2
    wr(2, 32'hFF);
    user_key = 8'hFB; tick(4);
    reset = 1;
    rd(2, 0, "rst_mask");
    rd(0, 0, "rst_state");
    chk("rst_irq", {31'h0, irq}, 0);
    tick(2);
    reset = 0;
    tick(5);
    rd(0, 0, "k2_state_early");
    tick(1);
    rd(0, 32'h04, "k2_state");
    rd(1, 32'h04, "k2_press");
    user_key = 8'hFF; tick(8);
    wr(1, 32'hFF);
    wr(3, 32'hFF);
    // key 7 press, and release capture when enabled
    wr(2, 32'h80);
    user_key = 8'h7F; tick(6);
    rd(1, 32'h80, "k7_press");
    chk("k7_irq", {31'h0, irq}, 1);
`ifdef KEY_RELEASE_EDGE_EN
    user_key = 8'hFF; tick(5);
    rd(3, 0, "k7_rel_early");
    tick(1);
    rd(3, 32'h80, "k7_rel");
    wr(1, 32'h80);
    chk("k7_irq_rel_held", {31'h0, irq}, 1);
    wr(3, 32'h80);
    rd(3, 0, "k7_rel_clr");
    chk("k7_irq_clr", {31'h0, irq}, 0);
`else
    user_key = 8'hFF; tick(8);
    wr(3, 32'hFF);
    rd(3, 0, "rel_absent");
    wr(1, 32'h80);
    chk("k7_irq_clr", {31'h0, irq}, 0);
`endif
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
